// File: rtl/systolic_feeder_if.sv
// Operand write port, control and skewed stream bus of the systolic array feeder.
// The master side writes operands and starts sequences; the slave side is the feeder.
interface systolic_feeder_if #(
  parameter int DATA_W = 8
);
  logic              wr_en;
  logic              wr_sel;
  logic [3:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              busy;
  logic              arr_clear;
  logic              feed_done;
  logic [DATA_W-1:0] inp_west0;
  logic [DATA_W-1:0] inp_west4;
  logic [DATA_W-1:0] inp_west8;
  logic [DATA_W-1:0] inp_west12;
  logic [DATA_W-1:0] inp_north0;
  logic [DATA_W-1:0] inp_north1;
  logic [DATA_W-1:0] inp_north2;
  logic [DATA_W-1:0] inp_north3;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start,
    input  busy, arr_clear, feed_done,
    input  inp_west0, inp_west4, inp_west8, inp_west12,
    input  inp_north0, inp_north1, inp_north2, inp_north3
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start,
    output busy, arr_clear, feed_done,
    output inp_west0, inp_west4, inp_west8, inp_west12,
    output inp_north0, inp_north1, inp_north2, inp_north3
  );
endinterface

// File: rtl/systolic_feeder.sv
// Operand staging for a 4x4 systolic array: buffers A/B, clears the array, then
// streams diagonally skewed A rows (west) and B columns (north), drains, and signals done.
module systolic_feeder #(
  parameter int DATA_W       = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  systolic_feeder_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [2:0] LAST_STEP  = 3'd6;
  localparam logic [3:0] LAST_DRAIN = 4'(DRAIN_CYCLES - 1);

  state_t            state_r;
  state_t            next_s;
  logic [2:0]        step_r;
  logic [2:0]        step_next_s;
  logic [3:0]        drain_r;
  logic [3:0]        drain_next_s;
  logic [DATA_W-1:0] a_r [16];
  logic [DATA_W-1:0] b_r [16];
  logic [DATA_W-1:0] west_r [4];
  logic [DATA_W-1:0] north_r [4];
  logic [DATA_W-1:0] west_next_s [4];
  logic [DATA_W-1:0] north_next_s [4];
  logic              busy_r;
  logic              clear_r;
  logic              done_r;
  logic              feed_next_s;

  // Sequence control: next state from current state, start and the counters
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) next_s = CLEAR;
        else           next_s = IDLE;
      end
      CLEAR: next_s = FEED;
      FEED: begin
        if (step_r == LAST_STEP) next_s = DRAIN;
        else                     next_s = FEED;
      end
      DRAIN: begin
        if (drain_r == LAST_DRAIN) next_s = DONE;
        else                       next_s = DRAIN;
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Step/drain counters restart at 0 on entry to their state
  always_comb begin
    step_next_s  = 3'd0;
    drain_next_s = 4'd0;
    if ((next_s == FEED) && (state_r == FEED)) step_next_s = step_r + 3'd1;
    else                                       step_next_s = 3'd0;
    if ((next_s == DRAIN) && (state_r == DRAIN)) drain_next_s = drain_r + 4'd1;
    else                                         drain_next_s = 4'd0;
  end

  // Skew decode: row i carries A[i][c] at step i+c, column j carries B[r][j] at step r+j
  always_comb begin
    feed_next_s = (next_s == FEED);
    for (int i = 0; i < 4; i++) begin
      west_next_s[i]  = '0;
      north_next_s[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 4; c++) begin
        west_next_s[i]  = west_next_s[i] |
                          ((feed_next_s && (step_next_s == 3'(i + c))) ? a_r[i*4 + c] : '0);
        north_next_s[i] = north_next_s[i] |
                          ((feed_next_s && (step_next_s == 3'(c + i))) ? b_r[c*4 + i] : '0);
      end
    end
  end

  // State, counters and registered outputs decoded from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      step_r  <= 3'd0;
      drain_r <= 4'd0;
      busy_r  <= 1'b0;
      clear_r <= 1'b0;
      done_r  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        west_r[i]  <= '0;
        north_r[i] <= '0;
      end
    end else begin
      state_r <= next_s;
      step_r  <= step_next_s;
      drain_r <= drain_next_s;
      busy_r  <= (next_s != IDLE);
      clear_r <= (next_s == CLEAR);
      done_r  <= (next_s == DONE);
      for (int i = 0; i < 4; i++) begin
        west_r[i]  <= west_next_s[i];
        north_r[i] <= north_next_s[i];
      end
    end
  end

  // Operand buffers accept writes only while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 16; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
      end
    end else if ((state_r == IDLE) && bus.wr_en) begin
      if (bus.wr_sel) b_r[bus.wr_addr] <= bus.wr_data;
      else            a_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.busy       = busy_r;
  assign bus.arr_clear  = clear_r;
  assign bus.feed_done  = done_r;
  assign bus.inp_west0  = west_r[0];
  assign bus.inp_west4  = west_r[1];
  assign bus.inp_west8  = west_r[2];
  assign bus.inp_west12 = west_r[3];
  assign bus.inp_north0 = north_r[0];
  assign bus.inp_north1 = north_r[1];
  assign bus.inp_north2 = north_r[2];
  assign bus.inp_north3 = north_r[3];

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: per-cycle reference model of the skewed streams
// plus a table of hand-computed vectors and multi-cycle corner-case sequences.
module tb_systolic_feeder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  systolic_feeder_if #(.DATA_W(8)) bus ();

  systolic_feeder #(.DATA_W(8), .DRAIN_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][7:0] w;
    logic [3:0][7:0] n;
    logic            busy;
    logic            clr;
    logic            done;
  } snap_t;

  // sig: 0..3 west rows, 4..7 north columns, 8 busy, 9 arr_clear, 10 feed_done
  typedef struct {
    int k;
    int sig;
    int exp;
  } vec_t;

  snap_t caps [14];
  vec_t  vecs [$];
  int    ma [16];
  int    mb [16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic snap_t take();
    snap_t s;
    s.w[0] = bus.inp_west0;  s.w[1] = bus.inp_west4;
    s.w[2] = bus.inp_west8;  s.w[3] = bus.inp_west12;
    s.n[0] = bus.inp_north0; s.n[1] = bus.inp_north1;
    s.n[2] = bus.inp_north2; s.n[3] = bus.inp_north3;
    s.busy = bus.busy;
    s.clr  = bus.arr_clear;
    s.done = bus.feed_done;
    return s;
  endfunction

  function automatic int field(input snap_t s, input int sig);
    if (sig < 4)       return int'(s.w[sig]);
    else if (sig < 8)  return int'(s.n[sig-4]);
    else if (sig == 8) return int'(s.busy);
    else if (sig == 9) return int'(s.clr);
    else               return int'(s.done);
  endfunction

  function automatic int exp_field(input int k, input int sig);
    int t;
    t = k - 1;
    if (sig == 8) return (k <= 12) ? 1 : 0;
    if (sig == 9) return (k == 0) ? 1 : 0;
    if (sig == 10) return (k == 12) ? 1 : 0;
    if (k < 1 || k > 7) return 0;
    if (sig < 4) begin
      if (t - sig >= 0 && t - sig <= 3) return ma[sig*4 + (t - sig)];
      return 0;
    end
    if (t - (sig-4) >= 0 && t - (sig-4) <= 3) return mb[(t - (sig-4))*4 + (sig-4)];
    return 0;
  endfunction

  task automatic wr(input bit sel, input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_addr = 4'(addr);
    bus.wr_data = 8'(data);
    @(posedge clk); #1;
    bus.wr_en   = 1'b0;
    if (sel) mb[addr] = data;
    else     ma[addr] = data;
  endtask

  task automatic load_default();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        wr(1'b0, r*4 + c, 4*r + c + 1);
        wr(1'b1, r*4 + c, 16 + 4*r + c);
      end
  endtask

  // Entered #1 after an edge with the DUT idle; caps[k] holds outputs after edge E0+k.
  // inj_k >= 0 pulses a write of A[0][0]=0xFF plus start while busy; pre_wr writes A[pre_addr]
  // together with start; tail_start raises start during DONE and leaves it high.
  task automatic run_seq(input string tag, input int inj_k, input bit pre_wr,
                         input int pre_addr, input int pre_data, input bit tail_start);
    bus.start = 1'b1;
    if (pre_wr) begin
      bus.wr_en   = 1'b1;
      bus.wr_sel  = 1'b0;
      bus.wr_addr = 4'(pre_addr);
      bus.wr_data = 8'(pre_data);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    for (int k = 0; k < 14; k++) begin
      caps[k] = take();
      for (int s = 0; s < 11; s++)
        chk($sformatf("%s k%0d sig%0d", tag, k, s), field(caps[k], s), exp_field(k, s));
      if (k == inj_k) begin
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = 4'd0;
        bus.wr_data = 8'hFF;
        bus.start   = 1'b1;
      end else if (k == inj_k + 1) begin
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
      end
      if (tail_start && k == 12) bus.start = 1'b1;
      if (k < 13) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    snap_t s;
    int    w0 [7]  = '{1, 2, 3, 4, 0, 0, 0};
    int    w4 [7]  = '{0, 5, 6, 7, 8, 0, 0};
    int    w12 [7] = '{0, 0, 0, 13, 14, 15, 16};
    int    n3 [7]  = '{0, 0, 0, 19, 23, 27, 31};

    checks = 0;
    errors = 0;
    for (int t = 0; t < 7; t++) begin
      vecs.push_back('{t+1, 0, w0[t]});
      vecs.push_back('{t+1, 1, w4[t]});
      vecs.push_back('{t+1, 3, w12[t]});
      vecs.push_back('{t+1, 7, n3[t]});
    end
    vecs.push_back('{0, 9, 1});
    vecs.push_back('{1, 9, 0});
    vecs.push_back('{11, 10, 0});
    vecs.push_back('{12, 10, 1});
    vecs.push_back('{13, 10, 0});
    vecs.push_back('{12, 8, 1});
    vecs.push_back('{13, 8, 0});

    for (int k = 0; k < 16; k++) begin
      ma[k] = 0;
      mb[k] = 0;
    end
    rst         = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 1'b0;
    bus.wr_addr = 4'd0;
    bus.wr_data = 8'd0;
    bus.start   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    s = take();
    for (int sg = 0; sg < 11; sg++) chk($sformatf("reset sig%0d", sg), field(s, sg), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Plan items 1 and 2: reference load, model plus hand-computed table
    load_default();
    run_seq("seq1", -5, 1'b0, 0, 0, 1'b0);
    foreach (vecs[v])
      chk($sformatf("table k%0d sig%0d", vecs[v].k, vecs[v].sig),
          field(caps[vecs[v].k], vecs[v].sig), vecs[v].exp);

    // Write and start while busy are ignored; replay still shows the original A[0][0]
    run_seq("busywr", 3, 1'b0, 0, 0, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("no restart busy", int'(bus.busy), 0);
    end
    run_seq("replay", -5, 1'b0, 0, 0, 1'b0);
    chk("replay A00", int'(caps[1].w[0]), 1);

    // Asynchronous reset at FEED step 3
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("step3 west0 before reset", int'(bus.inp_west0), 4);
    #2 rst = 1'b0;
    #1;
    s = take();
    for (int sg = 0; sg < 11; sg++) chk($sformatf("async rst sig%0d", sg), field(s, sg), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post reset busy", int'(bus.busy), 0);
    for (int k = 0; k < 16; k++) begin
      ma[k] = 0;
      mb[k] = 0;
    end
    run_seq("zeros", -5, 1'b0, 0, 0, 1'b0);

    // Same-cycle write and start
    load_default();
    ma[9] = 8'h5A;
    run_seq("wrstart", -5, 1'b1, 9, 8'h5A, 1'b0);
    chk("west8 step3 0x5A", int'(caps[4].w[2]), 8'h5A);

    // Back-to-back: start held through DONE is ignored there, accepted the cycle after
    run_seq("b2b first", -5, 1'b0, 0, 0, 1'b1);
    run_seq("b2b second", -5, 1'b0, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Operand staging and skew stage directly upstream of the 4x4 systolic array. Two 4x4 matrices of 8-bit operands are loaded through a byte-wide write port: A (west/row operand) and B (north/column operand). On start, the block pulses the array clear and then streams diagonally skewed rows of A into the west inputs and columns of B into the north inputs. After a drain period it signals completion.

Parameters:
DATA_W, 8, operand width; matches array input width.
DRAIN_CYCLES, 4, zero-padded cycles after the last operand so the array's far corner finishes accumulating; legal range 1..15.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
wr_en  input  1  operand write strobe.
wr_sel  input  1  0 = matrix A, 1 = matrix B.
wr_addr  input  4  element index = row*4 + col.
wr_data  input  DATA_W  operand value.
start  input  1  begin a feed sequence; sampled in IDLE only.
busy  output  1  high from CLEAR through DONE inclusive.
arr_clear  output  1  active-high clear for array accumulators; high exactly in CLEAR.
inp_west0, inp_west4, inp_west8, inp_west12  output  DATA_W each  row 0..3 west streams.
inp_north0..inp_north3  output  DATA_W each  column 0..3 north streams.
feed_done  output  1  one-cycle pulse in DONE.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE.
  - All outputs 0.
  - Both operand buffers cleared to 0.
  - Step and drain counters 0.
  - Reset mid-sequence aborts immediately. After release the block is in IDLE with cleared buffers.
- Writes:
  - With wr_en high in IDLE, A[wr_addr/4][wr_addr%4] or B[...] (per wr_sel) takes wr_data on the edge.
  - Writes while busy are ignored and the buffers are unchanged.
  - A write and start in the same IDLE cycle: the write lands, and the feed uses the updated value.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
  - IDLE: outputs 0. start=1 moves to CLEAR on the next edge. start is ignored in all other states (no queuing).
  - CLEAR (1 cycle): arr_clear=1, streams 0.
  - FEED (7 cycles, step t=0..6):
    - inp_west(4i) = A[i][t-i] when 0 <= t-i <= 3, else 0.
    - inp_north(j) = B[t-j][j] when 0 <= t-j <= 3, else 0.
  - DRAIN (DRAIN_CYCLES cycles): streams 0.
  - DONE (1 cycle): feed_done=1, busy=1, streams 0. Then IDLE.
- All outputs are registered and decoded from the next state, so the value for a state or step is visible in the cycle the FSM is in that state or step.
- Latency, with start sampled at edge E0:
  - arr_clear high after E0.
  - FEED step t visible after edge E(1+t).
  - Last operand is A[3][3] on inp_west12 and B[3][3] on inp_north3 after E7.
  - feed_done high after E(8+DRAIN_CYCLES).
  - busy low after E(9+DRAIN_CYCLES).
  - Total busy = 9 + DRAIN_CYCLES cycles (13 at default).
- Buffers persist across sequences. A second start with no new writes replays identical streams.
- Step counter is 3 bits and the drain counter is 4 bits. Neither wraps within a sequence.

Test Plan:
1. Load A[r][c]=4r+c+1 and B[r][c]=16+4r+c; start -> inp_west0 over steps 0..6 = 1,2,3,4,0,0,0. inp_west4 = 0,5,6,7,8,0,0. inp_west12 = 0,0,0,13,14,15,16. inp_north3 = 0,0,0,19,23,27,31.
2. Same load, start at E0 -> arr_clear high exactly 1 cycle after E0; busy high 13 cycles; feed_done a single pulse after E12; all streams 0 during CLEAR, DRAIN and DONE.
3. Assert wr_en with A[0][0]=0xFF, and pulse start, during FEED -> buffer unchanged; stream unaffected; no restart; a subsequent replay still shows A[0][0] original value.
4. Drive rst low at FEED step 3 -> all outputs 0 immediately (asynchronous, before the next edge). After release: IDLE, busy=0, and a start with no writes streams all zeros.
5. Same-cycle wr_en (A[2][1]=0x5A) and start in IDLE -> inp_west8 shows 0x5A at step 3.
6. Two back-to-back starts, the second issued the cycle after feed_done -> second sequence identical to the first; start during DONE is ignored.
